ac_sample_feeder: RTL and testbench

Upstream stage of the accumulator. Buffers 8-bit samples arriving on a valid/ready stream and drives them one per cycle onto the accumulator's `in` port, zero-filling bubbles. Owns the accumulator's `rst` line, pulsing it to close each frame of `FRAME_LEN` samples, and flags the cycle in which the accumulator's `sum` holds a complete frame total.

---
 rtl/ac_pkg.sv | 15 +
 rtl/ac_sample_feeder_if.sv | 16 +
 rtl/ac_sync_fifo.sv | 70 +++++++
 rtl/ac_sample_feeder.sv | 114 +++++++++++
 tb/tb_ac_sample_feeder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ac_pkg.sv
// ac_pkg: shared types and widths for the accumulator sample feeder.
//   SAMPLE_W       : width of one sample / accumulator input
//   SUM_W          : width of the accumulator sum and of the underrun counter
//   feeder_state_e : feeder FSM state (CLEAR closes a frame, STREAM feeds samples)
package ac_pkg;

    localparam int SAMPLE_W = 8;
    localparam int SUM_W    = 16;

    typedef enum logic {
        CLEAR,
        STREAM
    } feeder_state_e;

endpackage

// File: rtl/ac_sample_feeder_if.sv
// ac_sample_feeder_if: valid/ready sample stream into the feeder.
//   s_valid : upstream has a sample
//   s_data  : the sample
//   s_ready : feeder can accept (registered on the feeder side)
// Modports: master = upstream producer, slave = feeder.
interface ac_sample_feeder_if;
    import ac_pkg::*;

    logic                s_valid;
    logic [SAMPLE_W-1:0] s_data;
    logic                s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ac_sync_fifo.sv
// ac_sync_fifo: single-clock FIFO, DEPTH entries (power of two) of WIDTH bits.
//   clk, rst  : clock, synchronous active-low reset (flushes pointers/level)
//   push/wdata: write tail; ignored while can_push is low
//   pop/rdata : read head; rdata is the current head, pop ignored when empty
//   empty     : level == 0
//   can_push  : registered "level < DEPTH" for the coming cycle, 0 in reset
//   level     : occupancy, 0..DEPTH
module ac_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   can_push,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [LVL_W-1:0] level_nx;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign do_push = push && can_push;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_comb begin
        level_nx = level;
        if (do_push && !do_pop)
            level_nx = level + LVL_W'(1);
        else if (do_pop && !do_push)
            level_nx = level - LVL_W'(1);
    end

    // Pointers are exactly PTR_W bits, so wrap modulo DEPTH is free.
    // can_push looks at the next level so it falls in the same cycle
    // the FIFO reports full.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            can_push <= 1'b0;
        end else begin
            if (do_push)
                wptr <= wptr + PTR_W'(1);
            if (do_pop)
                rptr <= rptr + PTR_W'(1);
            level    <= level_nx;
            can_push <= (level_nx < LVL_W'(DEPTH));
        end
    end

    // Storage is not reset; a flush only needs the pointers and level.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/ac_sample_feeder.sv
// ac_sample_feeder: buffers stream samples and feeds the accumulator one
// sample per cycle, closing every FRAME_LEN samples with a clear pulse.
//   clk, rst     : clock, synchronous active-low reset
//   samples      : ac_sample_feeder_if.slave upstream stream
//   acc_in       : accumulator input, 0 on bubbles and clear cycles
//   acc_clr      : accumulator reset, active high
//   frame_done   : accumulator sum holds a complete frame total this cycle
//   level        : FIFO occupancy
//   underrun_cnt : saturating count of in-frame bubble cycles
// Optional feature macro: AC_FEEDER_UNDERRUN_EN (builds the underrun counter;
// without it underrun_cnt is tied to 0).
module ac_sample_feeder
    import ac_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ac_sample_feeder_if.slave      samples,
    output logic [SAMPLE_W-1:0]    acc_in,
    output logic                   acc_clr,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] level,
    output logic [SUM_W-1:0]       underrun_cnt
);
    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    feeder_state_e       state;
    logic [CNT_W-1:0]    frame_cnt;
    logic                closing;
    logic                ready;
    logic                fifo_empty;
    logic [SAMPLE_W-1:0] fifo_rdata;
    logic                push;
    logic                pop;

    assign samples.s_ready = ready;
    assign push            = samples.s_valid && ready;
    assign pop             = (state == STREAM) && !fifo_empty;

    ac_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (samples.s_data),
        .pop      (pop),
        .rdata    (fifo_rdata),
        .empty    (fifo_empty),
        .can_push (ready),
        .level    (level)
    );

    // Outputs are registered, so they show the work of the state one cycle
    // later: the CLEAR state is the no-pop cycle in which the frame's last
    // sample sits on acc_in; its clear pulse lands on the cycle after, which
    // is exactly when the accumulator sum holds the full total.
    // 'closing' separates a frame-ending CLEAR from the one after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLEAR;
            frame_cnt  <= '0;
            closing    <= 1'b0;
            acc_in     <= '0;
            acc_clr    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    acc_in     <= '0;
                    acc_clr    <= 1'b1;
                    frame_done <= closing;
                    closing    <= 1'b0;
                    state      <= STREAM;
                end
                STREAM: begin
                    acc_clr    <= 1'b0;
                    frame_done <= 1'b0;
                    if (!fifo_empty) begin
                        acc_in <= fifo_rdata;
                        if (frame_cnt == CNT_LAST) begin
                            frame_cnt <= '0;
                            closing   <= 1'b1;
                            state     <= CLEAR;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end else begin
                        acc_in <= '0;
                    end
                end
            endcase
        end
    end

`ifdef AC_FEEDER_UNDERRUN_EN
    // A bubble only counts once the frame has started; idle time between
    // frames is not an underrun.
    always_ff @(posedge clk) begin
        if (!rst)
            underrun_cnt <= '0;
        else if (state == STREAM && fifo_empty && frame_cnt != '0 &&
                 underrun_cnt != '1)
            underrun_cnt <= underrun_cnt + SUM_W'(1);
    end
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_ac_sample_feeder.sv
// tb_ac_sample_feeder: directed bench for ac_sample_feeder. Two instances:
// dut (FRAME_LEN=16) for framing/bubble/abort/random checks and dut1
// (FRAME_LEN=1) for the back-pressure scoreboard. Each drives a small
// accumulator model (sum <= clr ? 0 : sum + in).
module tb_ac_sample_feeder;

`ifdef AC_FEEDER_UNDERRUN_EN
    localparam logic [15:0] EXP_UR = 16'd3;
`else
    localparam logic [15:0] EXP_UR = 16'd0;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  acc_in,  acc_in1;
    logic        acc_clr, acc_clr1;
    logic        frame_done, frame_done1;
    logic [3:0]  level, level1;
    logic [15:0] underrun_cnt, underrun_cnt1;
    logic [15:0] sum0, sum1;

    int tests = 0;
    int fails = 0;
    int frames = 0;
    bit rnd_on = 0;
    logic [7:0] exp_q[$];
    logic [7:0] q1[$];

    ac_sample_feeder_if up ();
    ac_sample_feeder_if up1 ();

    ac_sample_feeder #(.DEPTH(8), .FRAME_LEN(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .samples      (up),
        .acc_in       (acc_in),
        .acc_clr      (acc_clr),
        .frame_done   (frame_done),
        .level        (level),
        .underrun_cnt (underrun_cnt)
    );

    ac_sample_feeder #(.DEPTH(8), .FRAME_LEN(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .samples      (up1),
        .acc_in       (acc_in1),
        .acc_clr      (acc_clr1),
        .frame_done   (frame_done1),
        .level        (level1),
        .underrun_cnt (underrun_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        sum0 <= acc_clr  ? 16'd0 : sum0 + 16'(acc_in);
        sum1 <= acc_clr1 ? 16'd0 : sum1 + 16'(acc_in1);
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_on && frame_done) begin
            int s;
            s = 0;
            chk("rnd_frame_avail", 32'(exp_q.size() >= 16), 1);
            for (int i = 0; i < 16; i++)
                if (exp_q.size() > 0) s += int'(exp_q.pop_front());
            chk("rnd_frame_sum", 32'(sum0), s);
            frames++;
        end
    endtask

    // Ends in the first cycle after reset release (CLEAR visible, STREAM state).
    task automatic do_reset();
        rst = 1'b0;
        up.s_valid  = 1'b0;
        up1.s_valid = 1'b0;
        step();
        step();
        chk("rst_acc_clr", acc_clr, 1);
        chk("rst_acc_in", acc_in, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_s_ready", up.s_ready, 0);
        chk("rst_level", level, 0);
        chk("rst_underrun", underrun_cnt, 0);
        rst = 1'b1;
        step();
        chk("post_rst_acc_clr", acc_clr, 1);
        chk("post_rst_s_ready", up.s_ready, 1);
        chk("post_rst_frame_done", frame_done, 0);
    endtask

    // 16 back-to-back pushes of v starting from an idle STREAM with empty FIFO.
    task automatic run_frame(logic [7:0] v, logic [15:0] exp_sum);
        for (int c = 2; c <= 20; c++) begin
            up.s_valid = (c <= 17);
            up.s_data  = v;
            step();
            chk("frame_acc_in", acc_in, (c >= 3 && c <= 18) ? v : 8'h00);
            chk("frame_acc_clr", acc_clr, 32'(c == 19));
            chk("frame_done", frame_done, 32'(c == 19));
            if (c == 19) chk("frame_sum", sum0, exp_sum);
            if (c == 20) chk("frame_sum_cleared", sum0, 0);
        end
    endtask

    initial begin
        int k;
        int n;
        bit seen_full;
        logic [7:0] last1;
        logic [7:0] want;

        rst = 1'b0;
        up.s_valid = 1'b0;  up.s_data = 8'h00;
        up1.s_valid = 1'b0; up1.s_data = 8'h00;
        last1 = 8'h00;

        // Frames of all ones and all 0xFF.
        do_reset();
        run_frame(8'h01, 16'd16);
        run_frame(8'hFF, 16'h0FF0);

        // Back-pressure on the FRAME_LEN=1 instance (drains at half rate).
        k = 1; seen_full = 0; q1.delete();
        for (int c = 0; c < 150; c++) begin
            up1.s_valid = (k <= 30);
            up1.s_data  = 8'(k);
            if (up1.s_valid && up1.s_ready) begin
                q1.push_back(up1.s_data);
                k++;
            end
            step();
            chk("stall_ready_vs_level", up1.s_ready, 32'(level1 < 4'd8));
            if (level1 == 4'd8) seen_full = 1;
            if (frame_done1) chk("stall_frame_sum", sum1, 32'(last1));
            if (!acc_clr1 && acc_in1 != 8'h00) begin
                last1 = acc_in1;
                if (q1.size() > 0) chk("stall_order", acc_in1, q1.pop_front());
                else chk("stall_extra", acc_in1, 0);
            end
        end
        up1.s_valid = 1'b0;
        chk("stall_full_seen", 32'(seen_full), 1);
        chk("stall_all_pushed", k, 31);
        chk("stall_all_popped", q1.size(), 0);
        chk("stall_underrun", underrun_cnt1, 0);

        // Three-cycle bubble mid-frame: samples 1..8, gap, 9..16.
        do_reset();
        k = 1;
        for (int c = 2; c <= 23; c++) begin
            up.s_valid = (c <= 9) || (c >= 13 && c <= 20);
            up.s_data  = 8'(k);
            if (up.s_valid) begin
                chk("bub_s_ready", up.s_ready, 1);
                k++;
            end
            step();
            if (c >= 3 && c <= 10)       want = 8'(c - 2);
            else if (c >= 14 && c <= 21) want = 8'(c - 5);
            else                         want = 8'h00;
            chk("bub_acc_in", acc_in, want);
            if (c == 22) begin
                chk("bub_frame_done", frame_done, 1);
                chk("bub_frame_sum", sum0, 136);
                chk("bub_underrun", underrun_cnt, EXP_UR);
            end
        end

        // Abort a frame after 7 samples with a one-cycle reset.
        for (int c = 2; c <= 8; c++) begin
            up.s_valid = 1'b1;
            up.s_data  = 8'h05;
            step();
        end
        chk("pre_abort_level", level, 1);
        up.s_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("abort_level", level, 0);
        chk("abort_acc_clr", acc_clr, 1);
        chk("abort_frame_done", frame_done, 0);
        rst = 1'b1;
        step();
        chk("abort_post_acc_clr", acc_clr, 1);
        chk("abort_post_s_ready", up.s_ready, 1);
        run_frame(8'h03, 16'd48);

        // Random stream of 1000 samples with random valid.
        do_reset();
        exp_q.delete();
        frames = 0;
        n = 0;
        rnd_on = 1;
        for (int c = 0; c < 20000 && n < 1000; c++) begin
            up.s_valid = 1'($urandom_range(0, 1));
            up.s_data  = 8'($urandom);
            if (up.s_valid && up.s_ready) begin
                exp_q.push_back(up.s_data);
                n++;
            end
            step();
        end
        up.s_valid = 1'b0;
        repeat (40) step();
        rnd_on = 0;
        chk("rnd_pushes", n, 1000);
        chk("rnd_frames", frames, 62);
        chk("rnd_leftover", exp_q.size(), 8);
        chk("rnd_level", level, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
